video_pattern_gen: RTL and testbench



---
 rtl/vpg_pkg.sv | 28 ++
 rtl/vpg_axis_counter.sv | 46 ++++
 rtl/video_pattern_gen.sv | 178 +++++++++++++++++
 tb/tb_video_pattern_gen.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/vpg_pkg.sv
// Shared definitions for the video pattern generator: pattern codes,
// colour-bar palette and the line/frame length helper.
package vpg_pkg;

  localparam logic [2:0] PAT_BARS   = 3'd0;
  localparam logic [2:0] PAT_RAMP   = 3'd1;
  localparam logic [2:0] PAT_CHECK  = 3'd2;
  localparam logic [2:0] PAT_MOVBAR = 3'd3;

  // Bar palette indexed by bar number; entry 0 (rightmost) is the leftmost bar.
  localparam logic [7:0][23:0] BAR_RGB = {
    24'h000000,  // 7 black
    24'h0000FF,  // 6 blue
    24'hFF0000,  // 5 red
    24'hFF00FF,  // 4 magenta
    24'h00FF00,  // 3 green
    24'h00FFFF,  // 2 cyan
    24'hFFFF00,  // 1 yellow
    24'hFFFFFF   // 0 white
  };

  // Total length of one axis (pixels per line or lines per frame).
  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vpg_axis_counter.sv
// One timing axis (horizontal or vertical): position counter with wrap,
// sync and blank decode. Position 0 is the first active pixel/line.
module vpg_axis_counter
  import vpg_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int CNT_W  = 10
) (
  input  logic             clk,
  input  logic             enable,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic             sync,
  output logic             blank
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CNT_W-1:0] LAST        = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] BLANK_START = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_START  = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_END    = CNT_W'(ACTIVE + FP + SYNC);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign wrap  = enable && (cnt_q == LAST);
  assign cnt   = cnt_q;
  assign blank = (cnt_q >= BLANK_START);
  assign sync  = (cnt_q >= SYNC_START) && (cnt_q < SYNC_END);

  // Next position: advance on enable, wrap after the last position.
  always_comb begin
    cnt_d = cnt_q;
    if (enable) cnt_d = wrap ? '0 : cnt_q + 1'b1;
  end

  // Position register; clear restarts the axis at 0.
  always_ff @(posedge clk) begin
    if (clear) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/video_pattern_gen.sv
// Free-running video timing and test-pattern source (colour bars, grey ramp,
// checkerboard, moving bar). Define VPG_MOVING_BAR_EN to build the moving-bar
// pattern; without it pattern 3 repeats the colour bars.
module video_pattern_gen
  import vpg_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk_vid,
  input  logic       reset,
  input  logic       ce_pix,
  input  logic [2:0] pattern,
  output logic [7:0] R_out,
  output logic [7:0] G_out,
  output logic [7:0] B_out,
  output logic       HSync_out,
  output logic       VSync_out,
  output logic       HBlank_out,
  output logic       VBlank_out,
  output logic       frame_start
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  // Ramp needs hcnt[7:0] and checkerboard needs vcnt[4], so keep at least 8 bits.
  localparam int H_W = ($clog2(H_TOTAL + 1) > 8) ? $clog2(H_TOTAL + 1) : 8;
  localparam int V_W = ($clog2(V_TOTAL + 1) > 8) ? $clog2(V_TOTAL + 1) : 8;
  localparam int BAR_W  = H_ACTIVE / 8;
  localparam int BAR_CW = $clog2(BAR_W + 1);
  localparam logic [BAR_CW-1:0] BAR_LAST = BAR_CW'(BAR_W - 1);

  logic [H_W-1:0] hcnt;
  logic [V_W-1:0] vcnt;
  logic           h_wrap, h_sync, h_blank;
  logic           v_wrap, v_sync, v_blank;

  vpg_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CNT_W(H_W)
  ) u_hcnt (
    .clk(clk_vid), .enable(ce_pix), .clear(reset),
    .cnt(hcnt), .wrap(h_wrap), .sync(h_sync), .blank(h_blank)
  );

  vpg_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CNT_W(V_W)
  ) u_vcnt (
    .clk(clk_vid), .enable(ce_pix && h_wrap), .clear(reset),
    .cnt(vcnt), .wrap(v_wrap), .sync(v_sync), .blank(v_blank)
  );

  // first_q marks that the next pixel emitted opens a frame (after reset or a frame wrap).
  logic             first_q, first_d;
  logic [2:0]       pat_q, pat_d, pat_sel;
  logic [BAR_CW-1:0] bar_px_q, bar_px_d;
  logic [2:0]       bar_idx_q, bar_idx_d;
  logic [23:0]      rgb_q, rgb_d, rgb_pix;
  logic             hs_q, hs_d, vs_q, vs_d, hb_q, hb_d, vb_q, vb_d, fs_q, fs_d;

`ifdef VPG_MOVING_BAR_EN
  logic [H_W-1:0] xpos_q, xpos_d;

  // Bar position steps by 4 each frame; the new value applies from the next frame.
  always_comb begin
    xpos_d = xpos_q;
    if (v_wrap) xpos_d = (int'(xpos_q) + 4 >= H_ACTIVE) ? '0 : xpos_q + H_W'(4);
  end

  // Bar position register.
  always_ff @(posedge clk_vid) begin
    if (reset) xpos_q <= '0;
    else       xpos_q <= xpos_d;
  end
`endif

  // Frame-start tracking, pattern latch and bar sub-counter next state.
  always_comb begin
    first_d   = first_q;
    pat_sel   = first_q ? pattern : pat_q;
    pat_d     = pat_q;
    bar_px_d  = bar_px_q;
    bar_idx_d = bar_idx_q;
    if (ce_pix) begin
      first_d = v_wrap;
      pat_d   = pat_sel;
      if (h_wrap) begin
        bar_px_d  = '0;
        bar_idx_d = '0;
      end else if (bar_px_q == BAR_LAST) begin
        bar_px_d  = '0;
        bar_idx_d = bar_idx_q + 1'b1;
      end else begin
        bar_px_d = bar_px_q + 1'b1;
      end
    end
  end

  // Pixel colour for the current position, forced black in blanking.
  always_comb begin
    rgb_pix = 24'h000000;
    case (pat_sel)
      PAT_BARS:  rgb_pix = BAR_RGB[bar_idx_q];
      PAT_RAMP:  rgb_pix = {3{hcnt[7:0]}};
      PAT_CHECK: rgb_pix = (hcnt[4] ^ vcnt[4]) ? 24'hFFFFFF : 24'h000000;
      PAT_MOVBAR: begin
`ifdef VPG_MOVING_BAR_EN
        if ((hcnt >= xpos_q) && (int'(hcnt) < int'(xpos_q) + 16)) rgb_pix = 24'hFFFFFF;
        else                                                       rgb_pix = 24'h000040;
`else
        rgb_pix = BAR_RGB[bar_idx_q];
`endif
      end
      default:   rgb_pix = 24'h000000;
    endcase
    if (h_blank || v_blank) rgb_pix = 24'h000000;
  end

  // Output next state: capture on ce_pix, otherwise hold.
  always_comb begin
    rgb_d = rgb_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    hb_d  = hb_q;
    vb_d  = vb_q;
    fs_d  = fs_q;
    if (ce_pix) begin
      rgb_d = rgb_pix;
      hs_d  = h_sync;
      vs_d  = v_sync;
      hb_d  = h_blank;
      vb_d  = v_blank;
      fs_d  = (hcnt == '0) && (vcnt == '0);
    end
  end

  // State and output registers.
  always_ff @(posedge clk_vid) begin
    if (reset) begin
      first_q   <= 1'b1;
      pat_q     <= PAT_BARS;
      bar_px_q  <= '0;
      bar_idx_q <= '0;
      rgb_q     <= 24'h000000;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      hb_q      <= 1'b1;
      vb_q      <= 1'b1;
      fs_q      <= 1'b0;
    end else begin
      first_q   <= first_d;
      pat_q     <= pat_d;
      bar_px_q  <= bar_px_d;
      bar_idx_q <= bar_idx_d;
      rgb_q     <= rgb_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      hb_q      <= hb_d;
      vb_q      <= vb_d;
      fs_q      <= fs_d;
    end
  end

  assign R_out       = rgb_q[23:16];
  assign G_out       = rgb_q[15:8];
  assign B_out       = rgb_q[7:0];
  assign HSync_out   = hs_q;
  assign VSync_out   = vs_q;
  assign HBlank_out  = hb_q;
  assign VBlank_out  = vb_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Scoreboard bench for video_pattern_gen: full-width lines with a short
// frame (25 lines) so several frames fit in the run.
module tb_video_pattern_gen;

  localparam int HA = 640, HF = 16, HS = 96, HB = 48;
  localparam int VA = 20, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;  // 800
  localparam int VT = VA + VF + VS + VB;  // 25

  logic       clk_vid = 1'b0;
  logic       reset   = 1'b1;
  logic       ce_pix  = 1'b1;
  logic [2:0] pattern = 3'd0;
  logic [7:0] R_out, G_out, B_out;
  logic       HSync_out, VSync_out, HBlank_out, VBlank_out, frame_start;

  video_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk_vid(clk_vid), .reset(reset), .ce_pix(ce_pix), .pattern(pattern),
    .R_out(R_out), .G_out(G_out), .B_out(B_out),
    .HSync_out(HSync_out), .VSync_out(VSync_out),
    .HBlank_out(HBlank_out), .VBlank_out(VBlank_out),
    .frame_start(frame_start)
  );

  always #5 clk_vid = ~clk_vid;

  // Expected pixel: frame/column/line since reset, colour and flags {fs,hs,vs,hb,vb}.
  typedef struct {
    int          fr;
    int          h;
    int          v;
    logic [23:0] rgb;
    logic [4:0]  fl;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   k     = 0;  // pixels issued since reset

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endfunction

  function automatic void expect_px(int fr, int h, int v, logic [23:0] rgb,
                                    logic [4:0] fl, string name);
    exp_t e;
    e.fr = fr; e.h = h; e.v = v; e.rgb = rgb; e.fl = fl; e.name = name;
    q.push_back(e);
  endfunction

  // Monitor: a pixel is presented after each posedge with ce_pix=1 and no reset.
  logic em_q = 1'b0, rs_q = 1'b0;
  always @(posedge clk_vid) begin
    em_q <= ce_pix && !reset;
    rs_q <= reset;
  end

  int          mh = 0, mv = 0, mf = 0;
  logic [28:0] last_out;
  always @(negedge clk_vid) begin
    logic [28:0] cur;
    cur = {R_out, G_out, B_out, frame_start, HSync_out, VSync_out, HBlank_out, VBlank_out};
    if (rs_q) begin
      mh = 0; mv = 0; mf = 0;
    end else if (em_q) begin
      while (q.size() > 0 && q[0].fr == mf && q[0].h == mh && q[0].v == mv) begin
        check({q[0].name, "_rgb"}, {8'h0, cur[28:5]}, {8'h0, q[0].rgb});
        check({q[0].name, "_flags"}, {27'h0, cur[4:0]}, {27'h0, q[0].fl});
        void'(q.pop_front());
      end
      mh++;
      if (mh == HT) begin
        mh = 0; mv++;
        if (mv == VT) begin mv = 0; mf++; end
      end
    end else begin
      check("hold", {3'h0, cur}, {3'h0, last_out});
    end
    last_out = cur;
  end

  // Issue pixels until the next one to be emitted is (h,v) of frame fr.
  task automatic run_to(int fr, int h, int v, bit half);
    int target;
    target = fr * HT * VT + v * HT + h;
    while (k < target) begin
      if (half) begin ce_pix = 1'b0; @(negedge clk_vid); end
      ce_pix = 1'b1;
      @(negedge clk_vid);
      k++;
    end
    ce_pix = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk_vid);
    check("rst_rgb",   {8'h0, R_out, G_out, B_out}, 32'h0);
    check("rst_flags", {27'h0, frame_start, HSync_out, VSync_out, HBlank_out, VBlank_out}, 32'h3);

    // Frame 0: colour bars; pattern switches to checkerboard at line 10.
    expect_px(0,   0,  0, 24'hFFFFFF, 5'b10000, "bars_0_0");
    expect_px(0,   1,  0, 24'hFFFFFF, 5'b00000, "bars_1_0");
    expect_px(0,  79,  0, 24'hFFFFFF, 5'b00000, "bars_79");
    expect_px(0,  80,  0, 24'hFFFF00, 5'b00000, "bars_80");
    expect_px(0, 160,  0, 24'h00FFFF, 5'b00000, "bars_160");
    expect_px(0, 240,  0, 24'h00FF00, 5'b00000, "bars_240");
    expect_px(0, 320,  0, 24'hFF00FF, 5'b00000, "bars_320");
    expect_px(0, 400,  0, 24'hFF0000, 5'b00000, "bars_400");
    expect_px(0, 480,  0, 24'h0000FF, 5'b00000, "bars_480");
    expect_px(0, 560,  0, 24'h000000, 5'b00000, "bars_560");
    expect_px(0, 639,  0, 24'h000000, 5'b00000, "bars_639");
    expect_px(0, 640,  0, 24'h000000, 5'b00010, "hblank_640");
    expect_px(0, 655,  0, 24'h000000, 5'b00010, "hsync_pre_655");
    expect_px(0, 656,  0, 24'h000000, 5'b01010, "hsync_656");
    expect_px(0, 751,  0, 24'h000000, 5'b01010, "hsync_751");
    expect_px(0, 752,  0, 24'h000000, 5'b00010, "hsync_post_752");
    expect_px(0, 799,  0, 24'h000000, 5'b00010, "line_end_799");
    expect_px(0,   0,  1, 24'hFFFFFF, 5'b00000, "line1_0");
    expect_px(0,  16, 10, 24'hFFFFFF, 5'b00000, "midchg_16_10");
    expect_px(0, 100, 15, 24'hFFFF00, 5'b00000, "midchg_100_15");
    expect_px(0,   0, 19, 24'hFFFFFF, 5'b00000, "last_active_line");
    expect_px(0,   0, 20, 24'h000000, 5'b00001, "vblank_20");
    expect_px(0,   0, 21, 24'h000000, 5'b00101, "vsync_21");
    expect_px(0, 700, 22, 24'h000000, 5'b01111, "vsync_hsync_22");
    expect_px(0,   0, 23, 24'h000000, 5'b00001, "vsync_end_23");
    expect_px(0, 799, 24, 24'h000000, 5'b00011, "frame_end");

    reset = 1'b0;
    run_to(0, 0, 2, 1'b1);   // first two lines with ce_pix every 2nd clock
    run_to(0, 0, 10, 1'b0);
    pattern = 3'd2;

    // Frame 1: checkerboard; pattern switches to ramp at line 2.
    expect_px(1,   0,  0, 24'h000000, 5'b10000, "chk_0_0");
    expect_px(1,  16,  0, 24'hFFFFFF, 5'b00000, "chk_16_0");
    expect_px(1,  32,  0, 24'h000000, 5'b00000, "chk_32_0");
    expect_px(1, 700,  5, 24'h000000, 5'b01010, "chk_blank");
    expect_px(1,   0, 16, 24'hFFFFFF, 5'b00000, "chk_0_16");
    expect_px(1,  16, 16, 24'h000000, 5'b00000, "chk_16_16");
    run_to(1, 0, 2, 1'b0);
    pattern = 3'd1;

    // Frame 2: grey ramp; pattern switches to 3 at line 3.
    expect_px(2,   0,  0, 24'h000000, 5'b10000, "ramp_0");
    expect_px(2, 255,  1, 24'hFFFFFF, 5'b00000, "ramp_255");
    expect_px(2, 256,  1, 24'h000000, 5'b00000, "ramp_256");
    expect_px(2, 300,  1, 24'h2C2C2C, 5'b00000, "ramp_300");
    expect_px(2, 700,  1, 24'h000000, 5'b01010, "ramp_700");
    run_to(2, 0, 3, 1'b0);
    pattern = 3'd3;

    // Frame 3: pattern 3.
`ifdef VPG_MOVING_BAR_EN
    expect_px(3,   0,  0, 24'h000040, 5'b10000, "mov_0");
    expect_px(3,  11,  0, 24'h000040, 5'b00000, "mov_11");
    expect_px(3,  12,  0, 24'hFFFFFF, 5'b00000, "mov_12");
    expect_px(3,  27,  0, 24'hFFFFFF, 5'b00000, "mov_27");
    expect_px(3,  28,  0, 24'h000040, 5'b00000, "mov_28");
    expect_px(3, 639,  0, 24'h000040, 5'b00000, "mov_639");
`else
    expect_px(3,   0,  0, 24'hFFFFFF, 5'b10000, "pat3_0");
    expect_px(3,  80,  0, 24'hFFFF00, 5'b00000, "pat3_80");
    expect_px(3, 480,  0, 24'h0000FF, 5'b00000, "pat3_480");
    expect_px(3, 560,  0, 24'h000000, 5'b00000, "pat3_560");
`endif
    run_to(3, 300, 2, 1'b0);

    // Mid-frame reset with ce_pix held high.
    ce_pix = 1'b1;
    reset  = 1'b1;
    @(negedge clk_vid);
    @(negedge clk_vid);
    check("midrst_rgb",   {8'h0, R_out, G_out, B_out}, 32'h0);
    check("midrst_flags", {27'h0, frame_start, HSync_out, VSync_out, HBlank_out, VBlank_out}, 32'h3);
    check("queue_drained", q.size(), 32'd0);

    pattern = 3'd1;
    k = 0;
    expect_px(0,   0,  0, 24'h000000, 5'b10000, "post_rst_0");
    expect_px(0,   5,  0, 24'h050505, 5'b00000, "post_rst_5");
    expect_px(0, 300,  0, 24'h2C2C2C, 5'b00000, "post_rst_300");
    reset = 1'b0;
    run_to(0, 301, 0, 1'b0);
    repeat (2) @(negedge clk_vid);

    while (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: pixel (%0d,%0d) frame %0d never emitted, required rgb %h",
               q[0].name, q[0].h, q[0].v, q[0].fr, q[0].rgb);
      void'(q.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
